// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, branch
// opcodes and the instruction field positions used by the decoder.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OPC_BRF = 4'hC;
    localparam logic [3:0] OPC_BRB = 4'hD;
    localparam logic [3:0] OPC_BZF = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    // Opcode lives in the top nibble of a 16-bit instruction word.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

endpackage

// File: rtl/fetch_decode.sv
// Combinational next-pc control decode: turns the held instruction and the
// condition flag into a one-hot inc/add/sub request, branch offset and halt.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int IMMW = 12
) (
    input  logic [DW-1:0] ir,
    input  logic          zflag,
    output logic          inc_n,
    output logic          add_n,
    output logic          sub_n,
    output logic [AW-1:0] offset_n,
    output logic          halt_n
);

    logic [3:0]    opcode;
    logic [AW-1:0] imm_ext;

    assign opcode  = ir[OPC_HI:OPC_LO];
    assign imm_ext = {{(AW-IMMW){1'b0}}, ir[IMMW-1:0]};

    always_comb begin
        inc_n    = 1'b0;
        add_n    = 1'b0;
        sub_n    = 1'b0;
        halt_n   = 1'b0;
        offset_n = '0;
        case (opcode)
            OPC_BRF: add_n  = 1'b1;
            OPC_BRB: sub_n  = 1'b1;
            OPC_BZF: begin
                add_n = zflag;
                inc_n = ~zflag;
            end
            OPC_HLT: halt_n = 1'b1;
            default: inc_n  = 1'b1;
        endcase
        // Plain increments always carry a zero offset.
        if (add_n || sub_n) begin
            offset_n = imm_ext;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: reads the instruction at pc, delivers it to decode, then
// pulses exactly one pc control (inc/add/sub) before fetching again.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int IMMW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          zflag,
    output logic          inc,
    output logic          add,
    output logic          sub,
    output logic [AW-1:0] offset,
    output logic          halted
);

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          inc_q, inc_d;
    logic          add_q, add_d;
    logic          sub_q, sub_d;
    logic [AW-1:0] offset_q, offset_d;

    logic          inc_n, add_n, sub_n, halt_n;
    logic [AW-1:0] offset_n;

    fetch_decode #(
        .AW   (AW),
        .DW   (DW),
        .IMMW (IMMW)
    ) u_decode (
        .ir       (ir_q),
        .zflag    (zflag),
        .inc_n    (inc_n),
        .add_n    (add_n),
        .sub_n    (sub_n),
        .offset_n (offset_n),
        .halt_n   (halt_n)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        // Controls are single-cycle pulses: cleared unless set below.
        inc_d      = 1'b0;
        add_d      = 1'b0;
        sub_d      = 1'b0;
        offset_d   = '0;
        case (state_q)
            ST_FETCH: begin
                mem_addr_d = pc;
                mem_req_d  = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir_valid_q && ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (halt_n) begin
                        state_d = ST_HALT;
                    end else begin
                        inc_d    = inc_n;
                        add_d    = add_n;
                        sub_d    = sub_n;
                        offset_d = offset_n;
                        state_d  = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            inc_q      <= 1'b0;
            add_q      <= 1'b0;
            sub_q      <= 1'b0;
            offset_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            inc_q      <= inc_d;
            add_q      <= add_d;
            sub_q      <= sub_d;
            offset_q   <= offset_d;
        end
    end

    // A reset landing in UPDATE must not let the pc load on that edge.
    assign inc      = inc_q & ~reset;
    assign add      = add_q & ~reset;
    assign sub      = sub_q & ~reset;
    assign offset   = reset ? '0 : offset_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized instruction
// streams, checked against an instruction-level pc/control model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        zflag = 1'b0;
    logic        inc, add, sub;
    logic [15:0] offset;
    logic        halted;

    logic        pc_ld = 1'b1;
    logic [15:0] pc_ld_val = '0;
    logic [15:0] exp_pc = '0;
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          last_pulse = -1;
    bit          chk_period = 1'b0;

    fetch_ctrl #(.AW(16), .DW(16), .IMMW(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .zflag     (zflag),
        .inc       (inc),
        .add       (add),
        .sub       (sub),
        .offset    (offset),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // The program counter the sequencer steers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_ld)    pc <= pc_ld_val;
        else if (inc) pc <= pc + 16'd1;
        else if (add) pc <= pc + offset;
        else if (sub) pc <= pc - offset;
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] v);
        @(negedge clk);
        reset = 1'b1; pc_ld = 1'b1; pc_ld_val = v;
        mem_ack = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0; pc_ld = 1'b0;
        exp_pc = v;
    endtask

    // One complete instruction: fetch, memory ack, decode handoff, pc update.
    task automatic run_instr(input logic [15:0] instr, input logic z,
                             input int ack_dly, input int rdy_dly);
        int          n;
        logic [15:0] addr0;
        logic [3:0]  opc;
        logic [15:0] imm;
        logic        e_inc, e_add, e_sub, e_hlt;
        logic [15:0] e_off;
        int          bad;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_req !== 1'b1) begin
            chk1("req_timeout", mem_req, 1'b1);
            return;
        end
        chk16("mem_addr", mem_addr, exp_pc);
        addr0 = mem_addr;
        for (int i = 0; i < ack_dly; i++) begin
            ir_ready  = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            @(negedge clk);
            chk1("req_hold", mem_req, 1'b1);
            chk16("addr_hold", mem_addr, addr0);
            chk1("ir_valid_idle", ir_valid, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = instr; ir_ready = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("ir_valid", ir_valid, 1'b1);
        chk16("ir", ir, instr);
        chk1("req_drop", mem_req, 1'b0);
        for (int i = 0; i < rdy_dly; i++) begin
            mem_ack = 1'b1; mem_rdata = 16'($urandom); zflag = ~z;
            @(negedge clk);
            mem_ack = 1'b0;
            chk16("ir_stable", ir, instr);
            chk1("ir_valid_hold", ir_valid, 1'b1);
            chk16("no_pulse_exec", {13'b0, inc, add, sub}, 16'h0);
        end
        zflag = z; ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0; zflag = 1'($urandom_range(0, 1));

        opc   = instr[15:12];
        imm   = {4'h0, instr[11:0]};
        e_inc = 1'b0; e_add = 1'b0; e_sub = 1'b0; e_hlt = 1'b0; e_off = '0;
        if (opc == 4'hF) e_hlt = 1'b1;
        else if (opc == 4'hC || (opc == 4'hE && z)) begin e_add = 1'b1; e_off = imm; end
        else if (opc == 4'hD) begin e_sub = 1'b1; e_off = imm; end
        else e_inc = 1'b1;

        chk1("ir_valid_clr", ir_valid, 1'b0);
        if (e_hlt) begin
            chk1("halted", halted, 1'b1);
            chk16("halt_no_pulse", {13'b0, inc, add, sub}, 16'h0);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_req !== 1'b0 || halted !== 1'b1 || {inc, add, sub} !== 3'b000) bad++;
            end
            chk16("halt_idle_20", 16'(bad), 16'h0);
            return;
        end
        chk1("inc", inc, e_inc);
        chk1("add", add, e_add);
        chk1("sub", sub, e_sub);
        chk16("offset", offset, e_off);
        chk1("not_halted", halted, 1'b0);
        if (chk_period && last_pulse >= 0) chk16("period", 16'(cyc - last_pulse), 16'd4);
        last_pulse = cyc;
        if (e_inc)      exp_pc = exp_pc + 16'd1;
        else if (e_add) exp_pc = exp_pc + e_off;
        else            exp_pc = exp_pc - e_off;
        @(negedge clk);
        chk16("pulse_clear", {13'b0, inc, add, sub}, 16'h0);
        chk16("offset_clear", offset, 16'h0);
    endtask

    initial begin
        logic [15:0] instr;
        // Reset state
        do_reset(16'h0000);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0);
        chk16("rst_ir", ir, 16'h0);
        chk1("rst_ir_valid", ir_valid, 1'b0);
        chk16("rst_ctrl", {13'b0, inc, add, sub}, 16'h0);
        chk16("rst_offset", offset, 16'h0);
        chk1("rst_halted", halted, 1'b0);

        // Straight-line code at the best-case rate
        chk_period = 1'b1;
        for (int i = 0; i < 4; i++) run_instr(16'h0000, 1'b0, 0, 0);
        chk_period = 1'b0;
        chk16("pc_after_4", exp_pc, 16'h0004);

        // Forward and backward branches, with wrap-around
        do_reset(16'h0010);
        run_instr(16'hC005, 1'b0, 0, 0);
        chk16("brf_target", exp_pc, 16'h0015);
        run_instr(16'h0000, 1'b0, 0, 0);
        do_reset(16'h0003);
        run_instr(16'hD005, 1'b0, 0, 0);
        chk16("brb_target", exp_pc, 16'hFFFE);
        run_instr(16'h0000, 1'b0, 0, 0);

        // Conditional branch both ways, then zero-immediate branches refetch
        run_instr(16'hE007, 1'b0, 0, 0);
        run_instr(16'hE007, 1'b1, 0, 0);
        run_instr(16'hC000, 1'b0, 0, 0);
        run_instr(16'hD000, 1'b0, 1, 1);

        // Slow memory and a stalled decode stage
        run_instr(16'h1234, 1'b0, 5, 3);

        // Randomized stream
        for (int k = 0; k < 60; k++) begin
            instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(instr, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Halt
        run_instr(16'hF000, 1'b0, 0, 0);

        // Reset landing in WAIT, with the ack arriving one cycle late
        do_reset(16'h0040);
        begin
            int n;
            n = 0;
            while (mem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk1("wait_reached", mem_req, 1'b1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hC005;
        chk1("rst_wait_req_drop", mem_req, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk16("late_ack_ir", ir, 16'h0);
        chk1("late_ack_valid", ir_valid, 1'b0);
        chk1("refetch_req", mem_req, 1'b1);
        chk16("refetch_addr", mem_addr, 16'h0040);
        run_instr(16'h0000, 1'b0, 0, 0);
        run_instr(16'hC003, 1'b1, 2, 0);
        run_instr(16'h0000, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
